sram_arbiter: RTL and testbench

- Round-robin arbiter that shares the single AHB-style port of sram_control between NUM_REQ requesters.
- Accepts byte read/write requests over a per-requester req/gnt handshake and issues single NONSEQ transfers, one per cycle at most.
- Produces the pipelined HWDATA for writes and routes HRDATA back to the requester that owns each read.
- Sits directly above sram_control. It drives HADDR/HWRITE/HTRANS/HWDATA and reads HRDATA.

---
 rtl/sram_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/sram_arbiter.sv | 126 ++++++++++++
 tb/tb_sram_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared constants, pipeline tag type and helpers for the SRAM arbiter slice.
// The tag data field is sized by DW_DEF; the top's DW parameter must match it.
package sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam int AW_DEF = 21;
    localparam int DW_DEF = 8;
    localparam int ID_W   = 3;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic [ID_W-1:0]   id;
        logic [DW_DEF-1:0] data;
    } tag_t;

    // Index of the set bit of a one-hot vector; zero when nothing is set.
    function automatic logic [ID_W-1:0] onehot_to_id(input logic [7:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) id = ID_W'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search for a winner starts at the registered pointer,
// and the pointer moves just past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [N-1:0]  i_req,
    input  logic          i_advance,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_ptr
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_win;
    logic [N-1:0]  w_upper;

    // Requests at or above the pointer win first; otherwise wrap to the lowest request.
    always_comb begin
        w_upper = '0;
        for (int i = 0; i < N; i++) begin
            w_upper[i] = i_req[i] && (PW'(i) >= r_ptr);
        end
        w_win = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) w_win = PW'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (w_upper[i]) w_win = PW'(i);
        end
        o_gnt = '0;
        if (|i_req) o_gnt[w_win] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (w_win == PW'(N - 1)) ? '0 : w_win + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/sram_arbiter.sv
// Shares the single AHB-style port of sram_control between NUM_REQ requesters:
// round-robin grant, address phase, write data phase and read return routing.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF
) (
    input  logic                  HCLK,
    input  logic                  reset_b,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    we,
    input  logic [NUM_REQ*AW-1:0] addr,
    input  logic [NUM_REQ*DW-1:0] wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DW-1:0]         rdata,
    output logic [AW-1:0]         HADDR,
    output logic                  HWRITE,
    output logic [1:0]            HTRANS,
    output logic [DW-1:0]         HWDATA,
    input  logic [DW-1:0]         HRDATA
);

    localparam int PW = $clog2(NUM_REQ);

    // req/gnt: a requester raises req with addr/we/wdata stable and keeps them
    // until gnt; the request is accepted at the rising edge where gnt is high.
    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_gnt;
    logic [PW-1:0]      w_ptr;
    logic               w_any;
    logic [ID_W-1:0]    w_win;
    logic [AW-1:0]      w_sel_addr;
    logic               w_sel_we;
    logic [DW-1:0]      w_sel_wdata;

    tag_t               r_s1;
    tag_t               r_s2;
    logic [AW-1:0]      r_haddr;
    logic               r_hwrite;
    logic [NUM_REQ-1:0] r_rvalid;
    logic [DW-1:0]      r_rdata;

    assign w_req = reset_b ? req : '0;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_clk     (HCLK),
        .i_rst_n   (reset_b),
        .i_req     (w_req),
        .i_advance (w_any),
        .o_gnt     (w_gnt),
        .o_ptr     (w_ptr)
    );

    assign w_any = |w_gnt;
    assign w_win = onehot_to_id(8'(w_gnt));

    // AND-OR select of the winner's fields; the grant is one-hot.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_we    = 1'b0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr  = addr[i*AW +: AW];
                w_sel_we    = we[i];
                w_sel_wdata = wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge HCLK or negedge reset_b) begin
        if (!reset_b) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_haddr  <= '0;
            r_hwrite <= 1'b0;
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_s1.valid <= w_any;
            if (w_any) begin
                r_s1.write <= w_sel_we;
                r_s1.id    <= w_win;
                r_s1.data  <= DW_DEF'(w_sel_wdata);
                r_haddr    <= w_sel_addr;
                r_hwrite   <= w_sel_we;
            end
            r_s2.valid <= r_s1.valid;
            r_s2.write <= r_s1.write;
            r_s2.id    <= r_s1.id;
            // Stage-2 data doubles as HWDATA, so it only moves on a write.
            if (r_s1.valid && r_s1.write) r_s2.data <= r_s1.data;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_rvalid[i] <= r_s2.valid && !r_s2.write && (r_s2.id == ID_W'(i));
            end
            if (r_s2.valid && !r_s2.write) r_rdata <= HRDATA;
        end
    end

    assign gnt    = w_gnt;
    assign HTRANS = r_s1.valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR  = r_haddr;
    assign HWRITE = r_hwrite;
    assign HWDATA = DW'(r_s2.data);
    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hold
            a_req_stable: assert property (@(posedge HCLK) disable iff (!reset_b)
                (req[gi] && !gnt[gi]) |=> (!req[gi] ||
                    ($stable(addr[gi*AW +: AW]) && $stable(we[gi]) &&
                     $stable(wdata[gi*DW +: DW]))));
        end
    endgenerate

    a_ptr_hold: assert property (@(posedge HCLK) disable iff (!reset_b)
        !w_any |=> (w_ptr == $past(w_ptr)));

    a_rvalid_onehot: assert property (@(posedge HCLK) disable iff (!reset_b)
        $onehot0(rvalid));

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small SRAM model and a read scoreboard.
module tb_sram_arbiter;

  localparam int N  = 4;
  localparam int AW = 21;
  localparam int DW = 8;

  logic            HCLK = 1'b0;
  logic            reset_b;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   HADDR;
  logic            HWRITE;
  logic [1:0]      HTRANS;
  logic [DW-1:0]   HWDATA;
  logic [DW-1:0]   HRDATA;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected read returns: {due cycle[15:0], requester id[2:0], data[7:0]}
  logic [26:0] exp_q[$];
  logic [7:0]  exp_mem [256];

  sram_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .HCLK    (HCLK),
    .reset_b (reset_b),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .gnt     (gnt),
    .rvalid  (rvalid),
    .rdata   (rdata),
    .HADDR   (HADDR),
    .HWRITE  (HWRITE),
    .HTRANS  (HTRANS),
    .HWDATA  (HWDATA),
    .HRDATA  (HRDATA)
  );

  // ---------------- clock / reset ----------------
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  // ---------------- SRAM model (indexed by the low address byte) ----------------
  logic [7:0] mem [256];
  logic       s_valid;
  logic       s_write;
  logic [7:0] s_idx;
  logic [7:0] hrdata_q;

  always @(posedge HCLK or negedge reset_b) begin
    if (!reset_b) begin
      s_valid <= 1'b0;
      s_write <= 1'b0;
      s_idx   <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      if (s_valid && s_write) mem[s_idx] <= HWDATA;
      s_valid <= (HTRANS == 2'b10);
      s_write <= HWRITE;
      s_idx   <= HADDR[7:0];
    end
  end

  always @(negedge HCLK) hrdata_q <= mem[s_idx];
  assign HRDATA = hrdata_q;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every nonzero rvalid must match the oldest expected read.
  always @(negedge HCLK) begin
    if (rvalid !== '0) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", 32'(rvalid), 32'h0);
      end else begin
        logic [26:0] e;
        e = exp_q.pop_front();
        chk("rvalid_id", 32'(rvalid), 32'(1) << e[10:8]);
        chk("rdata", 32'(rdata), 32'(e[7:0]));
        chk("rd_latency", 32'(cyc), 32'(e[26:11]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]            = 1'b1;
    we[i]             = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  // Called in the cycle requester i is granted.
  task automatic on_grant(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (w) exp_mem[a[7:0]] = d;
    else   exp_q.push_back({16'(cyc + 3), 3'(i), exp_mem[a[7:0]]});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic            c_we [N];
  logic [AW-1:0]   c_a  [N];
  logic [DW-1:0]   c_d  [N];

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    reset_b = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    tick();
    tick();

    // Reset state, including gnt suppressed while reset is low
    req = '1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_haddr", 32'(HADDR), 32'h0);
    chk("rst_hwrite", 32'(HWRITE), 32'h0);
    chk("rst_hwdata", 32'(HWDATA), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    req = '0;
    reset_b = 1'b1;
    tick();

    // Single write
    drive(0, 1'b1, 21'h00010, 8'hA5);
    #1;
    chk("wr_gnt", 32'(gnt), 32'b0001);
    on_grant(0, 1'b1, 21'h00010, 8'hA5);
    tick();
    req = '0;
    #1;
    chk("wr_htrans", 32'(HTRANS), 32'h2);
    chk("wr_haddr", 32'(HADDR), 32'h00010);
    chk("wr_hwrite", 32'(HWRITE), 32'h1);
    chk("idle_gnt", 32'(gnt), 32'h0);
    tick();
    chk("wr_hwdata", 32'(HWDATA), 32'hA5);
    chk("idle_htrans", 32'(HTRANS), 32'h0);
    chk("idle_haddr_hold", 32'(HADDR), 32'h00010);
    tick();

    // Read-back of the same address
    drive(0, 1'b0, 21'h00010, 8'h00);
    #1;
    chk("rd_gnt", 32'(gnt), 32'b0001);
    on_grant(0, 1'b0, 21'h00010, 8'h00);
    tick();
    req = '0;
    #1;
    chk("rd_htrans", 32'(HTRANS), 32'h2);
    chk("rd_hwrite", 32'(HWRITE), 32'h0);
    chk("rd_hwdata_hold", 32'(HWDATA), 32'hA5);
    repeat (4) tick();
    chk("rd_q_empty", 32'(exp_q.size()), 32'h0);

    // Sparse: only requester 3 with ptr = 1
    drive(3, 1'b1, 21'h00020, 8'h5A);
    #1;
    chk("sparse_gnt", 32'(gnt), 32'b1000);
    on_grant(3, 1'b1, 21'h00020, 8'h5A);
    tick();
    req = '0;
    #1;
    chk("sparse_htrans", 32'(HTRANS), 32'h2);
    chk("sparse_haddr", 32'(HADDR), 32'h00020);
    tick();
    chk("sparse_idle", 32'(HTRANS), 32'h0);
    chk("sparse_hwdata", 32'(HWDATA), 32'h5A);
    tick();
    chk("sparse_idle2", 32'(HTRANS), 32'h0);

    // Contention: all four requesting for 8 cycles; ptr must now be 0
    c_we[0] = 1'b1; c_a[0] = 21'h00030; c_d[0] = 8'($urandom_range(1, 255));
    c_we[1] = 1'b0; c_a[1] = 21'h00010; c_d[1] = 8'h00;
    c_we[2] = 1'b0; c_a[2] = 21'h00030; c_d[2] = 8'h00;
    c_we[3] = 1'b0; c_a[3] = 21'h00020; c_d[3] = 8'h00;
    for (int i = 0; i < N; i++) drive(i, c_we[i], c_a[i], c_d[i]);
    #1;
    for (int k = 0; k < 8; k++) begin
      int w;
      w = k % N;
      chk("cont_gnt", 32'(gnt), 32'(1) << w);
      on_grant(w, c_we[w], c_a[w], c_d[w]);
      tick();
      chk("cont_htrans", 32'(HTRANS), 32'h2);
      chk("cont_haddr", 32'(HADDR), 32'(c_a[w]));
      chk("cont_hwrite", 32'(HWRITE), 32'(c_we[w]));
    end
    req = '0;
    repeat (5) tick();
    chk("cont_q_empty", 32'(exp_q.size()), 32'h0);

    // Back-to-back write then read of the top address
    drive(1, 1'b1, 21'h1FFFFF, 8'h3C);
    #1;
    chk("b2b_wgnt", 32'(gnt), 32'b0010);
    on_grant(1, 1'b1, 21'h1FFFFF, 8'h3C);
    tick();
    req[1] = 1'b0;
    drive(2, 1'b0, 21'h1FFFFF, 8'h00);
    #1;
    chk("b2b_rgnt", 32'(gnt), 32'b0100);
    on_grant(2, 1'b0, 21'h1FFFFF, 8'h00);
    chk("b2b_w_haddr", 32'(HADDR), 32'h1FFFFF);
    chk("b2b_w_hwrite", 32'(HWRITE), 32'h1);
    tick();
    req = '0;
    #1;
    chk("b2b_r_htrans", 32'(HTRANS), 32'h2);
    chk("b2b_r_hwrite", 32'(HWRITE), 32'h0);
    chk("b2b_hwdata", 32'(HWDATA), 32'h3C);
    repeat (4) tick();
    chk("b2b_q_empty", 32'(exp_q.size()), 32'h0);

    // Reset in the data phase of a read: ptr is 3, so requester 1 wins
    drive(1, 1'b0, 21'h00010, 8'h00);
    #1;
    chk("rstmid_gnt", 32'(gnt), 32'b0010);
    tick();
    req = '0;
    tick();
    reset_b = 1'b0;
    exp_q.delete();
    #1;
    chk("rstmid_htrans", 32'(HTRANS), 32'h0);
    chk("rstmid_rvalid", 32'(rvalid), 32'h0);
    tick();
    tick();
    reset_b = 1'b1;
    #1;
    for (int i = 0; i < N; i++) drive(i, 1'b1, 21'(32'h40 + i), 8'(i));
    #1;
    chk("rstmid_first_gnt", 32'(gnt), 32'b0001);
    tick();
    req = '0;
    repeat (5) tick();
    chk("final_q_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
